// File: rtl/fp_normalize_round_pkg.sv
// Shared definitions for the floating-point post-add normalise/round stage:
// rounding-mode encoding, default format widths and the round-increment rule.
package definitions;

    typedef enum logic {
        RND_RNE = 1'b0,
        RND_RTZ = 1'b1
    } rnd_mode_t;

    localparam int FP_EXP_W = 8;
    localparam int FP_MNT_W = 23;

    // Decide whether the kept fraction is incremented, given its lsb and G/R/S.
    function automatic logic round_up(
        input rnd_mode_t mode,
        input logic      lsb,
        input logic      g,
        input logic      r,
        input logic      s
    );
        case (mode)
            RND_RNE: round_up = g & (r | s | lsb);
            RND_RTZ: round_up = 1'b0;
            default: round_up = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fp_normalize_round_shifter.sv
// Leading-one detector plus the two normalising shifts of the raw sum.
// shl_o moves the leading one up to the hidden position (bit W-2); it is only
// meaningful when the carry bit is clear. shr_o is the one-place right shift
// used when the carry bit is set, with the dropped bit folded into sticky.
// Both outputs omit the carry position, which is always zero once normalised.
module lead_one_shifter #(
    parameter  int W     = 28,
    localparam int IDX_W = $clog2(W)
) (
    input  logic [W-1:0]     mnt_i,
    output logic [IDX_W-1:0] lead_idx_o,
    output logic [W-2:0]     shl_o,
    output logic [W-2:0]     shr_o
);

    logic [IDX_W-1:0] shamt;

    // Highest set bit wins because later loop iterations overwrite earlier ones.
    always_comb begin
        lead_idx_o = '0;
        for (int i = 0; i < W; i++) begin
            lead_idx_o = mnt_i[i] ? IDX_W'(i) : lead_idx_o;
        end
    end

    // Left-shift distance that brings the leading one to the hidden position.
    always_comb begin
        if (lead_idx_o < IDX_W'(W - 2)) begin
            shamt = IDX_W'(W - 2) - lead_idx_o;
        end else begin
            shamt = '0;
        end
    end

    // Both candidate normalised mantissas; the caller selects on the carry bit.
    always_comb begin
        shl_o = mnt_i[W-2:0] << shamt;
        shr_o = {mnt_i[W-1:2], mnt_i[1] | mnt_i[0]};
    end

endmodule

// File: rtl/fp_normalize_round.sv
// Post-add stage of the FP adder: normalise the raw sum (S1), then round,
// detect overflow/underflow and pack the result (S2). Two-entry elastic
// pipeline with valid/ready on both sides; results leave in order.
module fp_normalize_round
    import definitions::*;
#(
    parameter  int EXP_W = FP_EXP_W,
    parameter  int MNT_W = FP_MNT_W,
    parameter  int DST_W = 4,
    localparam int M     = MNT_W + 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic             in_flip,
    input  logic             in_op,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [M-1:0]     in_mnt,
    input  logic             in_rnd,
    input  logic [DST_W-1:0] in_dst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [EXP_W-1:0] out_exp,
    output logic [MNT_W-1:0] out_frac,
    output logic [DST_W-1:0] out_dst,
    output logic             out_ovf,
    output logic             out_unf
);

    // Two extra exponent bits so the adjusted exponent never wraps:
    // the MSB acts as a sign bit for values that went to zero or below.
    localparam int            EW       = EXP_W + 2;
    localparam int            IDX_W    = $clog2(M);
    localparam logic [EW-1:0] NORM_POS = EW'(M - 2);
    localparam logic [EW-1:0] EXP_TOP  = EW'((1 << EXP_W) - 1);

    // S1 payload: normalised mantissa (hidden..S) and adjusted exponent.
    // A normalised nonzero value always has the hidden bit set, so a clear
    // hidden bit marks an exactly-zero sum.
    typedef struct packed {
        logic            sign;
        rnd_mode_t       rnd;
        logic [EW-1:0]   exp;
        logic [M-2:0]    mnt;
        logic [DST_W-1:0] dst;
    } s1_t;

    // S2 payload: the packed result exactly as presented on the outputs.
    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MNT_W-1:0] frac;
        logic             ovf;
        logic             unf;
        logic [DST_W-1:0] dst;
    } s2_t;

    logic             s1_valid_q, s1_valid_d;
    logic             s2_valid_q, s2_valid_d;
    s1_t              s1_q, s1_d;
    s2_t              s2_q, s2_d;
    s2_t              res;

    logic             s1_advance;
    logic             s2_advance;

    logic [IDX_W-1:0] lead_idx;
    logic [M-2:0]     mnt_shl;
    logic [M-2:0]     mnt_shr;
    logic [EW-1:0]    exp_ext;
    logic [EW-1:0]    idx_ext;

    logic             inc;
    logic             frac_carry;
    logic [MNT_W-1:0] frac_rnd;
    logic [EW-1:0]    exp_rnd;
    logic             is_zero;
    logic             ovf_cond;
    logic             unf_cond;

    lead_one_shifter #(
        .W (M)
    ) u_shifter (
        .mnt_i      (in_mnt),
        .lead_idx_o (lead_idx),
        .shl_o      (mnt_shl),
        .shr_o      (mnt_shr)
    );

    // Elastic handshake: S2 moves when empty or drained, S1 follows S2.
    always_comb begin
        s2_advance = !s2_valid_q | out_ready;
        s1_advance = s2_advance;
        in_ready   = !reset & (!s1_valid_q | s1_advance);
    end

    // Stage 1: capture the transaction with its normalised mantissa and exponent.
    always_comb begin
        exp_ext    = {2'b00, in_exp};
        idx_ext    = EW'(lead_idx);
        s1_d       = s1_q;
        s1_valid_d = s1_valid_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_d.sign = in_sign ^ (in_flip & in_op);
                s1_d.rnd  = rnd_mode_t'(in_rnd);
                s1_d.exp  = exp_ext + idx_ext - NORM_POS;
                s1_d.mnt  = in_mnt[M-1] ? mnt_shr : mnt_shl;
                s1_d.dst  = in_dst;
            end else begin
                s1_d = s1_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage 2 datapath: round, renormalise on carry-out, classify and pack.
    always_comb begin
        is_zero = ~s1_q.mnt[M-2];
        inc     = round_up(s1_q.rnd, s1_q.mnt[3], s1_q.mnt[2], s1_q.mnt[1], s1_q.mnt[0]);
        // Carry out of the fraction also carries out of the (set) hidden bit.
        {frac_carry, frac_rnd} = {1'b0, s1_q.mnt[M-3:3]} + {{MNT_W{1'b0}}, inc};
        exp_rnd  = s1_q.exp + (frac_carry ? EW'(1) : EW'(0));
        ovf_cond = !exp_rnd[EW-1] & (exp_rnd >= EXP_TOP);
        unf_cond = exp_rnd[EW-1] | (exp_rnd == '0);

        res      = '0;
        res.dst  = s1_q.dst;
        if (is_zero) begin
            res.sign = 1'b0;
        end else if (ovf_cond) begin
            res.sign = s1_q.sign;
            res.ovf  = 1'b1;
            if (s1_q.rnd == RND_RTZ) begin
                res.exp  = {{(EXP_W-1){1'b1}}, 1'b0};
                res.frac = '1;
            end else begin
                res.exp  = '1;
                res.frac = '0;
            end
        end else if (unf_cond) begin
            res.sign = s1_q.sign;
            res.unf  = 1'b1;
        end else begin
            res.sign = s1_q.sign;
            res.exp  = exp_rnd[EXP_W-1:0];
            res.frac = frac_rnd;
        end
    end

    // Stage 2 load: take the S1 result when advancing, otherwise hold stable.
    always_comb begin
        s2_d       = s2_q;
        s2_valid_d = s2_valid_q;
        if (s2_advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_d = res;
            end else begin
                s2_d = s2_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Pipeline registers; reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_sign  = s2_q.sign;
    assign out_exp   = s2_q.exp;
    assign out_frac  = s2_q.frac;
    assign out_ovf   = s2_q.ovf;
    assign out_unf   = s2_q.unf;
    assign out_dst   = s2_q.dst;

endmodule

// File: tb/tb_fp_normalize_round.sv
// Self-checking bench for fp_normalize_round (default parameters, M=28).
module tb_fp_normalize_round;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
        logic        ovf;
        logic        unf;
        logic [3:0]  dst;
    } res_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_sign, in_flip, in_op, in_rnd;
    logic [7:0]  in_exp;
    logic [27:0] in_mnt;
    logic [3:0]  in_dst;
    logic        out_valid, out_ready, out_sign, out_ovf, out_unf;
    logic [7:0]  out_exp;
    logic [22:0] out_frac;
    logic [3:0]  out_dst;
    res_t        cur;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign cur = {out_sign, out_exp, out_frac, out_ovf, out_unf, out_dst};

    fp_normalize_round dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_flip   (in_flip),
        .in_op     (in_op),
        .in_exp    (in_exp),
        .in_mnt    (in_mnt),
        .in_rnd    (in_rnd),
        .in_dst    (in_dst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_frac  (out_frac),
        .out_dst   (out_dst),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf)
    );

    // Reference: normalise with plain arithmetic on the integer value of the sum,
    // round on the three bits below the 24-bit significand, then classify.
    function automatic res_t ref_model(input logic s, input logic fl, input logic op,
                                       input logic [7:0] ex, input logic [27:0] m,
                                       input logic rtz, input logic [3:0] dst);
        res_t r;
        longint e;
        longint unsigned sig, grs;
        r = '0;
        r.dst = dst;
        if (m == 28'd0) return r;
        r.sign = s ^ (fl & op);
        sig = 64'(m);
        e = longint'(ex);
        if (sig >= 64'd134217728) begin          // 2^27: carry set
            sig = (sig / 2) | (sig % 2);
            e = e + 1;
        end else begin
            while (sig < 64'd67108864) begin     // 2^26: hidden position
                sig = sig * 2;
                e = e - 1;
            end
        end
        grs = sig % 8;
        sig = sig / 8;
        if (!rtz && grs >= 4 && (grs != 4 || sig % 2 == 1)) sig = sig + 1;
        if (sig == 64'd16777216) begin
            sig = sig / 2;
            e = e + 1;
        end
        if (e >= 255) begin
            r.ovf = 1'b1;
            r.exp  = rtz ? 8'hFE : 8'hFF;
            r.frac = rtz ? 23'h7FFFFF : 23'h0;
        end else if (e <= 0) begin
            r.unf = 1'b1;
        end else begin
            r.exp  = 8'(e);
            r.frac = 23'(sig - 64'd8388608);
        end
        return r;
    endfunction

    // Send one transaction with out_ready high; report latency and the result.
    task automatic run_one(input logic s, input logic fl, input logic op,
                           input logic [7:0] ex, input logic [27:0] m,
                           input logic rnd, input logic [3:0] dst,
                           output int lat, output res_t got);
        int guard;
        @(negedge clk);
        out_ready = 1'b1;
        in_sign = s; in_flip = fl; in_op = op; in_exp = ex;
        in_mnt = m; in_rnd = rnd; in_dst = dst; in_valid = 1'b1;
        #1;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk); #1; guard++;
        end
        @(posedge clk);
        n_vec++;
        @(negedge clk);
        in_valid = 1'b0;
        in_rnd = ~rnd;               // changes after acceptance must not matter
        lat = 1;
        #1;
        while (!out_valid && lat < 20) begin
            @(negedge clk); #1; lat++;
        end
        got = cur;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_sign = 1'b0; in_flip = 1'b0; in_op = 1'b0; in_rnd = 1'b0;
        in_exp = 8'd0; in_mnt = 28'd0; in_dst = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        if (cur !== res_t'(0)) begin n_err++; $display("FAIL reset_outputs: got %h want 0", cur); end
        reset = 1'b0;
        #1;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_passthrough();
        int lat; res_t got, want;
        run_one(1'b0, 1'b0, 1'b0, 8'd127, 28'h4000000, 1'b0, 4'd1, lat, got);
        want = '{1'b0, 8'd127, 23'd0, 1'b0, 1'b0, 4'd1};
        if (lat !== 2) begin n_err++; $display("FAIL latency: got %0d want 2", lat); end
        if (got !== want) begin n_err++; $display("FAIL one_passthrough: got %h want %h", got, want); end
        run_one(1'b0, 1'b0, 1'b0, 8'd127, 28'h8000000, 1'b0, 4'd2, lat, got);
        want = '{1'b0, 8'd128, 23'd0, 1'b0, 1'b0, 4'd2};
        if (got !== want) begin n_err++; $display("FAIL carry_renorm: got %h want %h", got, want); end
        run_one(1'b0, 1'b1, 1'b1, 8'd100, 28'h2000000, 1'b0, 4'd3, lat, got);
        want = '{1'b1, 8'd99, 23'd0, 1'b0, 1'b0, 4'd3};
        if (got !== want) begin n_err++; $display("FAIL sign_flip_shift: got %h want %h", got, want); end
    endtask

    task automatic test_rounding();
        logic [27:0] mv [4];
        logic        rv [4];
        logic [7:0]  ev [4];
        logic [22:0] fv [4];
        int lat; res_t got, want;
        mv = '{28'h4000004, 28'h400000C, 28'h400000C, 28'h7FFFFFC};
        rv = '{1'b0, 1'b0, 1'b1, 1'b0};
        ev = '{8'd127, 8'd127, 8'd127, 8'd128};
        fv = '{23'h0, 23'h2, 23'h1, 23'h0};
        for (int i = 0; i < 4; i++) begin
            run_one(1'b0, 1'b0, 1'b0, 8'd127, mv[i], rv[i], 4'(i + 4), lat, got);
            want = '{1'b0, ev[i], fv[i], 1'b0, 1'b0, 4'(i + 4)};
            if (got !== want) begin n_err++; $display("FAIL round_%0d: got %h want %h", i, got, want); end
        end
    endtask

    task automatic test_ovf_unf();
        int lat; res_t got, want;
        run_one(1'b0, 1'b0, 1'b0, 8'd254, 28'h8000000, 1'b0, 4'd8, lat, got);
        want = '{1'b0, 8'hFF, 23'h0, 1'b1, 1'b0, 4'd8};
        if (got !== want) begin n_err++; $display("FAIL ovf_rne: got %h want %h", got, want); end
        run_one(1'b0, 1'b0, 1'b0, 8'd254, 28'h8000000, 1'b1, 4'd9, lat, got);
        want = '{1'b0, 8'hFE, 23'h7FFFFF, 1'b1, 1'b0, 4'd9};
        if (got !== want) begin n_err++; $display("FAIL ovf_rtz: got %h want %h", got, want); end
        run_one(1'b0, 1'b0, 1'b0, 8'd254, 28'h4000000, 1'b0, 4'd10, lat, got);
        want = '{1'b0, 8'hFE, 23'h0, 1'b0, 1'b0, 4'd10};
        if (got !== want) begin n_err++; $display("FAIL max_no_ovf: got %h want %h", got, want); end
        run_one(1'b1, 1'b0, 1'b0, 8'd10, 28'h0000008, 1'b0, 4'd11, lat, got);
        want = '{1'b1, 8'h0, 23'h0, 1'b0, 1'b1, 4'd11};
        if (got !== want) begin n_err++; $display("FAIL unf_deep: got %h want %h", got, want); end
        run_one(1'b0, 1'b0, 1'b0, 8'd23, 28'h0000008, 1'b0, 4'd12, lat, got);
        want = '{1'b0, 8'h0, 23'h0, 1'b0, 1'b1, 4'd12};
        if (got !== want) begin n_err++; $display("FAIL unf_exp0: got %h want %h", got, want); end
        run_one(1'b0, 1'b0, 1'b0, 8'd24, 28'h0000008, 1'b0, 4'd13, lat, got);
        want = '{1'b0, 8'h1, 23'h0, 1'b0, 1'b0, 4'd13};
        if (got !== want) begin n_err++; $display("FAIL min_normal: got %h want %h", got, want); end
        run_one(1'b1, 1'b0, 1'b0, 8'd50, 28'h0, 1'b0, 4'd14, lat, got);
        want = '{1'b0, 8'h0, 23'h0, 1'b0, 1'b0, 4'd14};
        if (got !== want) begin n_err++; $display("FAIL zero: got %h want %h", got, want); end
    endtask

    task automatic test_backpressure();
        int sent, got_n, stall, cyc;
        bit seen_first, blocked;
        res_t snap;
        logic [3:0] tags [$];
        sent = 0; got_n = 0; stall = 0; seen_first = 0; blocked = 0; snap = '0;
        for (cyc = 0; cyc < 40 && got_n < 4; cyc++) begin
            @(negedge clk);
            if (out_valid && !seen_first) seen_first = 1;
            out_ready = !(seen_first && stall < 3);
            in_valid = (sent < 4);
            in_sign = 1'b0; in_flip = 1'b0; in_op = 1'b0; in_rnd = 1'b0;
            in_exp = 8'd127; in_mnt = 28'h4000000; in_dst = 4'(sent + 1);
            #1;
            if (seen_first && stall < 3) begin
                if (stall == 0) snap = cur;
                else if (cur !== snap || !out_valid) begin
                    n_err++; $display("FAIL bp_hold: got %h want %h", cur, snap);
                end
                if (!in_ready) blocked = 1;
                stall++;
            end
            if (out_valid && out_ready) begin tags.push_back(out_dst); got_n++; end
            if (in_valid && in_ready) begin sent++; n_vec++; end
        end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        if (!blocked) begin n_err++; $display("FAIL bp_in_ready_drop: got 1 want 0"); end
        if (tags.size() != 4) begin n_err++; $display("FAIL bp_count: got %0d want 4", tags.size()); end
        for (int i = 0; i < tags.size(); i++) begin
            if (tags[i] !== 4'(i + 1)) begin n_err++; $display("FAIL bp_order_%0d: got %0d want %0d", i, tags[i], i + 1); end
        end
    endtask

    task automatic test_reset_midstream();
        int guard;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_exp = 8'd127; in_mnt = 28'h4000000; in_dst = 4'd7;
        #1;
        guard = 0;
        while (in_ready && guard < 10) begin
            @(posedge clk); n_vec++;
            @(negedge clk); #1; guard++;
        end
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_err++; $display("FAIL rst_fill: got ready=%b valid=%b want ready=0 valid=1", in_ready, out_valid);
        end
        reset = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
        @(negedge clk);
        reset = 1'b0; out_ready = 1'b1;
        #1;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready: got %b want 1", in_ready); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_stale_%0d: got %b want 0", i, out_valid); end
        end
    endtask

    task automatic test_random();
        res_t q [$];
        res_t want, snap;
        bit stalled;
        stalled = 0; snap = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            if (cyc < 500) begin
                in_valid = ($urandom_range(0, 9) < 8);
                in_sign = 1'($urandom_range(0, 1)); in_flip = 1'($urandom_range(0, 1));
                in_op = 1'($urandom_range(0, 1)); in_rnd = 1'($urandom_range(0, 1));
                in_exp = 8'($urandom_range(0, 255)); in_dst = 4'($urandom_range(0, 15));
                in_mnt = 28'($urandom) >> $urandom_range(0, 27);
                out_ready = ($urandom_range(0, 9) < 7);
            end else begin
                in_valid = 1'b0; out_ready = 1'b1;
            end
            #1;
            if (stalled && (out_valid !== 1'b1 || cur !== snap)) begin
                n_err++; $display("FAIL rnd_hold: got %h want %h", cur, snap);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_err++; $display("FAIL rnd_extra: got %h want none", cur);
                end else begin
                    want = q.pop_front();
                    if (cur !== want) begin n_err++; $display("FAIL rnd_result: got %h want %h", cur, want); end
                end
            end
            stalled = out_valid && !out_ready;
            snap = cur;
            if (in_valid && in_ready) begin
                q.push_back(ref_model(in_sign, in_flip, in_op, in_exp, in_mnt, in_rnd, in_dst));
                n_vec++;
            end
        end
        if (q.size() != 0) begin n_err++; $display("FAIL rnd_drain: got %0d left want 0", q.size()); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_rounding();
        test_ovf_unf();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fp_normalize_round.md
# fp_normalize_round

Parametrised, pipelined post-add stage of the floating-point adder: takes the raw overflow-expanded sum with guard/round/sticky bits, normalises it, rounds it per a selectable mode, and packs sign/exponent/fraction with overflow and underflow flags. It sits after the mantissa add/subtract stage and before writeback. It has a two-stage elastic pipeline with valid/ready handshakes on both sides, so the adder can stall on backpressure.

## Interface
- `EXP_W`, default 8: exponent width.
- `MNT_W`, default 23: stored fraction width. Internal mantissa width is `M = MNT_W+5`: 1 carry bit, 1 hidden bit, `MNT_W` fraction bits, then G, R, S.
- `DST_W`, default 4: destination tag width.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`: input, 1 bit, rising-edge clock.
- `reset`: input, 1 bit, synchronous active-high reset.
- `in_valid`: input, 1 bit, upstream transaction present.
- `in_ready`: output, 1 bit, block accepts the upstream transaction this cycle.
- `in_sign`, `in_flip`, `in_op`: input, 1 bit each, sign of the larger operand, operand-swap flag, subtract flag.
- `in_exp`: input, `EXP_W` bits, exponent of the larger operand.
- `in_mnt`: input, `M` bits, raw sum. Bit `M-1` is carry, bit `M-2` is hidden, bits `[2:0]` are G/R/S.
- `in_rnd`: input, 1 bit, rounding mode (`RND_RNE`=0, `RND_RTZ`=1), captured with the transaction.
- `in_dst`: input, `DST_W` bits, tag carried through unchanged.
- `out_valid`: output, 1 bit, result present.
- `out_ready`: input, 1 bit, downstream consumes the result.
- `out_sign`: output, 1 bit; `out_exp`: output, `EXP_W` bits; `out_frac`: output, `MNT_W` bits; `out_dst`: output, `DST_W` bits.
- `out_ovf`, `out_unf`: output, 1 bit each, overflow and underflow flags.

## Operation
- **Sign.** `sign = in_sign ^ (in_flip & in_op)`.
- **Stage 1 (normalise).**
  - Find leading-one index `p` of `in_mnt`.
  - If `p = M-1`: shift right 1, OR the dropped bit into S.
  - Otherwise: shift left `M-2-p`.
  - Adjusted exponent `e = in_exp + p - (M-2)`. Compute it signed, `EXP_W+2` bits, so it cannot wrap.
- **Zero input.** If `in_mnt == 0`, the result is exactly zero: exp 0, frac 0, sign 0, no flags.
- **Stage 2 (round).**
  - RNE: increment when `G & (R | S | lsb)`.
  - RTZ: never increment.
  - Rounding carry-out of the hidden bit: fraction becomes 0 and `e` increments.
- **Overflow, `e >= 2^EXP_W - 1`.** `out_ovf`=1.
  - RNE: infinity (exp all ones, frac 0).
  - RTZ: max finite (exp `2^EXP_W-2`, frac all ones).
- **Underflow, `e <= 0` with nonzero mantissa.** Flush to zero: exp 0, frac 0, sign kept, `out_unf`=1. The block produces no subnormals.
- **Otherwise.** `out_exp = e[EXP_W-1:0]`, `out_frac` = rounded fraction bits.

## Timing
- **Pipeline.** Two register stages (S1, S2). Latency is exactly 2 cycles from accepted input to `out_valid` when `out_ready`=1. Throughput is one result per cycle.
- **Output handshake.**
  - `out_ready` is honoured in the same cycle.
  - While `out_valid & !out_ready`, all `out_*` signals are held stable.
- **Stage advance.**
  - S2 advances when it is empty or consumed.
  - S1 advances when S2 accepts.
  - `in_ready = !s1_valid | s1_advance` (combinational from `out_ready`).
  - Transfer occurs on `in_valid & in_ready`.
- **Ordering.** Results leave in acceptance order. No transaction is dropped or duplicated.
- **Reset.**
  - While `reset` is high: `out_valid`=0, `in_ready`=0, and all `out_*` data and flags are 0.
  - `in_ready`=1 on the first cycle after `reset` deasserts.
- **Reset mid-operation.** In-flight transactions are discarded with no output; `out_valid` is 0 in the cycle after the reset edge.
- **Mode capture.** `in_rnd` is sampled only at acceptance. Changes while a transaction is in flight do not affect it.

## Structure
- **`definitions` package.** Add the `rnd_mode_t` enum (`RND_RNE`, `RND_RTZ`) and the default constants `FP_EXP_W=8` and `FP_MNT_W=23`.
- **Local structs.** The S1/S2 pipeline payloads are local `typedef struct packed` definitions inside the module, since their widths depend on the parameters.
- **Sub-module `lead_one_shifter #(W)`.** Combinational: outputs the leading-one index, the shifted mantissa, and the sticky-merged right shift. It is instantiated in stage 1.

## Test plan
All cases use default parameters (`M=28`).
- **1.0 passthrough.** `in_mnt=28'h4000000`, `in_exp=127`, RNE, `out_ready`=1 → 2 cycles later `out_exp=127`, `out_frac=0`, no flags.
- **Carry renormalise.** `in_mnt=28'h8000000`, `in_exp=127` → `out_exp=128`, `out_frac=0`.
- **Rounding modes.**
  - `28'h4000004` RNE → `frac 0x000000` (tie to even).
  - `28'h400000C` RNE → `frac 0x000002`.
  - `28'h400000C` RTZ → `frac 0x000001`.
  - `28'h7FFFFFC` RNE with `in_exp=127` → `exp 128`, `frac 0`.
- **Overflow and underflow.**
  - `in_exp=254`, `in_mnt=28'h8000000`: RNE → `exp 0xFF`, `frac 0`, `ovf`=1; RTZ → `exp 0xFE`, `frac 0x7FFFFF`, `ovf`=1.
  - `in_exp=10`, `in_mnt=28'h0000008` → zero, `unf`=1.
  - `in_mnt=0` → exp 0, frac 0, sign 0, no flags.
- **Backpressure.** Stream tags 1..4 back-to-back and hold `out_ready`=0 for 3 cycles after the first `out_valid` → `in_ready` drops once S1 and S2 are full, outputs stay stable, tags emerge 1,2,3,4 exactly once each.
- **Reset mid-stream.** Assert `reset` with both stages full → the next cycle has `out_valid`=0 and no stale result ever appears; `in_ready`=1 the cycle after `reset` deasserts.
